ledgame_sequencer: RTL
======================

Name: ledgame_sequencer

Overview:
- Round controller for the four-LED toggle game.
- Sits between the per-button press detectors and the per-LED toggle registers, and owns all toggle requests.
- Each round it scrambles the LEDs with pseudo-random legal moves, then forwards player presses as toggle masks and counts moves.
- On all-lit it detects the win, freezes input and blinks the display until a new round starts.

Parameters:
- SCRAMBLE_STEPS, 7: number of pseudo-random moves applied per round; must be ≥ 1.
- LFSR_SEED, 8'hA5: reset value of the 8-bit LFSR; must be nonzero.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period in WIN.
- MOVE_W, 8: width of the move counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a new round.
- pressed  in  4  single-cycle press pulses, one bit per button.
- led_state  in  4  current LED register values.
- toggle  out  4  per-LED toggle strobe to the LED registers; each bit high one cycle per flip.
- display  out  4  LED drive pattern for the board.
- moves  out  MOVE_W  accepted player moves this round; saturates at all-ones.
- won  out  1  high while in WIN.
- busy  out  1  high while in SCRAMBLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, toggle=0, display=0, moves=0, won=0, busy=0, lfsr=LFSR_SEED, step count=0, blink counter=0, blink phase=0.
- Move map: button i produces mask with bits i and (i+3) mod 4 set.
  - Button 0 -> 4'b1001, button 1 -> 4'b0011, button 2 -> 4'b0110, button 3 -> 4'b1100.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Steps every cycle in every state except reset, so press timing adds entropy.
- All outputs are registered.
- IDLE:
  - display=led_state; pressed is ignored.
  - start -> SCRAMBLE; step count=0, moves=0.
- SCRAMBLE (busy=1):
  - Every cycle, toggle=map(lfsr[1:0]) and the step count increments.
  - After SCRAMBLE_STEPS moves, wait one cycle with toggle=0 so led_state settles, then check led_state.
  - led_state==4'hF: issue one more random move and recheck.
  - Otherwise -> PLAY.
  - pressed is ignored throughout SCRAMBLE.
- PLAY:
  - Any nonzero pressed: toggle=map(lowest set index) on the next cycle (1-cycle latency) and moves += 1, saturating.
  - Simultaneous presses count as one move; the higher-index presses are dropped.
  - Win check: when toggle==0 in the current cycle and led_state==4'hF -> WIN.
  - Example timing: press at cycle n, toggle at n+1, led_state updates at n+2, won=1 at n+3.
  - A press arriving in the same cycle as the win check is dropped.
- WIN (won=1):
  - pressed is ignored; toggle=0.
  - Blink counter counts 0..BLINK_DIV-1; on wrap, blink phase inverts.
  - display = phase ? 4'h0 : 4'hF, with phase=0 on entry.
- start in PLAY or WIN restarts the round: -> SCRAMBLE, moves=0, won=0, blink counter and phase cleared.
- start in SCRAMBLE restarts the scramble: step count=0. lfsr is not reset.
- In IDLE, SCRAMBLE and PLAY, display=led_state.
- toggle is never nonzero in IDLE or WIN.
- Reset asserted mid-round returns to IDLE immediately; LED registers are not cleared by this block.

Test Plan:
- Reset, then start with SCRAMBLE_STEPS=7, LED model attached -> busy=1 for ≥8 cycles; exactly 7 one-hot-pair toggle masks, each from {1001,0011,0110,1100}; then PLAY with led_state≠4'hF.
- In PLAY with led_state=4'b0110, press button 0 at cycle n -> toggle=4'b1001 at n+1, moves=1, led_state=4'hF at n+2, won=1 at n+3.
- In PLAY, pressed=4'b1010 in one cycle -> toggle=4'b0011 only; moves increments by 1.
- In WIN with BLINK_DIV=4 -> display alternates 4'hF / 4'h0 every 4 cycles; pressed=4'hF produces toggle=0 and moves unchanged.
- With MOVE_W=2, make 5 presses without winning -> moves sequence 1,2,3,3,3.
- Assert rst_n low during SCRAMBLE step 3 -> outputs are reset values in the same cycle (async); after release, state=IDLE and no toggles occur until start.

Source files
------------

// File: rtl/ledgame_sequencer.sv
// Round controller for the four-LED toggle game: scrambles the board with
// LFSR-driven legal moves, forwards player presses as toggle masks, and blinks on a win.
module ledgame_sequencer #(
    parameter int         SCRAMBLE_STEPS = 7,
    parameter logic [7:0] LFSR_SEED      = 8'hA5,
    parameter int         BLINK_DIV      = 25_000_000,
    parameter int         MOVE_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        pressed,
    input  logic [3:0]        led_state,
    output logic [3:0]        toggle,
    output logic [3:0]        display,
    output logic [MOVE_W-1:0] moves,
    output logic              won,
    output logic              busy
);

    localparam int STEP_W  = $clog2(SCRAMBLE_STEPS + 2);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [STEP_W-1:0]  STEP_LAST   = STEP_W'(SCRAMBLE_STEPS);
    localparam logic [STEP_W-1:0]  STEP_SETTLE = STEP_W'(SCRAMBLE_STEPS + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCRAMBLE,
        PLAY,
        WIN
    } state_t;

    state_t             state_reg;
    logic [7:0]         lfsr_reg;
    logic [STEP_W-1:0]  step_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               phase_reg;

    logic [7:0] lfsr_next;
    logic [3:0] button_mask [4];
    logic [3:0] rand_mask;
    logic [3:0] press_mask;

    // Button i flips its own LED and the one below it (wrapping).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign button_mask[gi] = 4'((1 << gi) | (1 << ((gi + 3) % 4)));
        end
    endgenerate

    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign rand_mask = button_mask[lfsr_reg[1:0]];

    // Lowest-index press wins; higher simultaneous presses are dropped.
    always_comb begin
        press_mask = 4'h0;
        for (int i = 3; i >= 0; i--) begin
            if (pressed[i]) begin
                press_mask = button_mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lfsr_reg      <= LFSR_SEED;
            step_reg      <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            toggle        <= 4'h0;
            display       <= 4'h0;
            moves         <= '0;
            won           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            lfsr_reg <= lfsr_next;
            toggle   <= 4'h0;

            if (start) begin
                state_reg     <= SCRAMBLE;
                step_reg      <= '0;
                moves         <= '0;
                won           <= 1'b0;
                busy          <= 1'b1;
                blink_cnt_reg <= '0;
                phase_reg     <= 1'b0;
                display       <= led_state;
            end else begin
                case (state_reg)
                    IDLE: begin
                        display <= led_state;
                    end

                    SCRAMBLE: begin
                        display <= led_state;
                        if (step_reg < STEP_LAST) begin
                            toggle   <= rand_mask;
                            step_reg <= step_reg + 1'b1;
                        end else if (step_reg == STEP_LAST) begin
                            // Idle cycle so the last flip lands before the solved check.
                            step_reg <= STEP_SETTLE;
                        end else if (led_state == 4'hF) begin
                            toggle   <= rand_mask;
                            step_reg <= STEP_LAST;
                        end else begin
                            state_reg <= PLAY;
                            busy      <= 1'b0;
                        end
                    end

                    PLAY: begin
                        display <= led_state;
                        // Only trust led_state once no flip is in flight.
                        if (toggle == 4'h0 && led_state == 4'hF) begin
                            state_reg     <= WIN;
                            won           <= 1'b1;
                            display       <= 4'hF;
                            blink_cnt_reg <= '0;
                            phase_reg     <= 1'b0;
                        end else if (|pressed) begin
                            toggle <= press_mask;
                            if (moves != {MOVE_W{1'b1}}) begin
                                moves <= moves + 1'b1;
                            end
                        end
                    end

                    WIN: begin
                        if (blink_cnt_reg == BLINK_LAST) begin
                            blink_cnt_reg <= '0;
                            phase_reg     <= ~phase_reg;
                            display       <= phase_reg ? 4'hF : 4'h0;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + 1'b1;
                        end
                    end

                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
